// File: rtl/spi_bot_pkg.sv
// Shared definitions for the SPI bus-partner bots: response modes, FSM states
// and the CPOL/CPHA edge-selection rule.
package spi_bot_pkg;

  localparam logic [1:0] MODE_ECHO = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_INC  = 2'd2;
  localparam logic [1:0] MODE_FILL = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // True when the sample edge is the rising SCLK edge; the shift edge is the other one.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_slave_delay_reflector_if.sv
// SPI bus bundle between a master and the delay-reflector slave.
interface spi_slave_delay_reflector_if;
  logic SCLK;
  logic CS;
  logic MOSI;
  logic MISO;
  logic OUT_MISO_OE;

  modport master (output SCLK, CS, MOSI, input MISO, OUT_MISO_OE);
  modport slave  (input SCLK, CS, MOSI, output MISO, OUT_MISO_OE);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by an edge-detect stage.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one-cycle history for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_delay_reflector.sv
// Oversampled SPI slave that answers each frame with a transformed copy of the
// frame received DELAY_DEPTH frames earlier; everything runs on IN_CLK.
module spi_slave_delay_reflector
  import spi_bot_pkg::*;
#(
  parameter int unsigned CPHA                       = 1,
  parameter int unsigned CPOL                       = 1,
  parameter int unsigned PACK_LENGTH                = 8,
  parameter int unsigned PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int unsigned PACK_BIT_SEQUENCE_RECEIVE  = 1,
  parameter int unsigned DELAY_DEPTH                = 4,
  parameter logic [PACK_LENGTH-1:0] FILL            = '0
) (
  input  logic                   IN_CLK,
  input  logic                   IN_RESET,
  spi_slave_delay_reflector_if.slave bus,
  input  logic [1:0]             IN_MODE,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
  output logic                   OUT_FRAME_DONE,
  output logic                   OUT_FRAME_ERROR,
  output logic [15:0]            OUT_FRAME_COUNT
);

  localparam int   CW          = $clog2(PACK_LENGTH + 1);
  localparam int   PW          = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;
  localparam int   SLOTS       = 2 ** PW;
  localparam logic SAMPLE_RISE = sample_on_rise(CPOL != 0, CPHA != 0);

  function automatic logic [PACK_LENGTH-1:0] transform(input logic [1:0] mode,
                                                       input logic [PACK_LENGTH-1:0] w);
    case (mode)
      MODE_ECHO: return w;
      MODE_INV:  return ~w;
      MODE_INC:  return w + PACK_LENGTH'(1'b1);
      MODE_FILL: return FILL;
      default:   return w;
    endcase
  endfunction

  function automatic logic tx_bit(input logic [PACK_LENGTH-1:0] w, input logic [CW-1:0] idx);
    logic [PACK_LENGTH-1:0] sh;
    if (PACK_BIT_SEQUENCE_TRANSMIT != 0) begin
      sh = w << idx;
      return sh[PACK_LENGTH-1];
    end else begin
      sh = w >> idx;
      return sh[0];
    end
  endfunction

  function automatic logic [PACK_LENGTH-1:0] shift_rx(input logic [PACK_LENGTH-1:0] w, input logic b);
    if (PACK_BIT_SEQUENCE_RECEIVE != 0) begin
      return {w[PACK_LENGTH-2:0], b};
    end else begin
      return {b, w[PACK_LENGTH-1:1]};
    end
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DELAY_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  spi_sync_edge #(.RESET_VAL(CPOL != 0)) u_sync_sclk (
    .clk_i(IN_CLK), .rst_ni(IN_RESET), .async_i(bus.SCLK),
    .level_o(sclk_level_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s));
  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(IN_CLK), .rst_ni(IN_RESET), .async_i(bus.CS),
    .level_o(cs_level_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s));
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(IN_CLK), .rst_ni(IN_RESET), .async_i(bus.MOSI),
    .level_o(mosi_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s));

  assign unused_s = ^{sclk_level_s, mosi_rise_s, mosi_fall_s};

  logic sample_edge_s, shift_edge_s;
  assign sample_edge_s = SAMPLE_RISE ? sclk_rise_s : sclk_fall_s;
  assign shift_edge_s  = SAMPLE_RISE ? sclk_fall_s : sclk_rise_s;

  state_e                 state_q, state_d;
  logic [PACK_LENGTH-1:0] rx_q, rx_d, tx_q, tx_d, data_q, data_d;
  logic [CW-1:0]          cnt_q, cnt_d, idx_q, idx_d;
  logic                   first_q, first_d, miso_q, miso_d, oe_q, oe_d;
  logic                   done_q, done_d, err_q, err_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [15:0]            count_q, count_d;
  logic [PACK_LENGTH-1:0] delay_q [SLOTS];

  logic                   commit_s, load_s;
  logic [PW-1:0]          rd_next_s;
  logic [PACK_LENGTH-1:0] load_word_s;

  // The slot being committed this cycle is forwarded so a back-to-back frame
  // (DONE straight into ACTIVE) with DELAY_DEPTH=1 still sees the fresh word.
  assign commit_s    = (state_q == DONE) && (cnt_q == CW'(PACK_LENGTH));
  assign rd_next_s   = commit_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  assign load_word_s = transform(IN_MODE, (commit_s && (rd_next_s == wr_ptr_q)) ? rx_q
                                                                                : delay_q[rd_next_s]);

  // Next-state and datapath logic of the frame FSM.
  always_comb begin
    state_d  = state_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    first_d  = first_q;
    miso_d   = 1'b0;
    oe_d     = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    count_d  = count_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall_s) begin
          state_d = ACTIVE;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_rise_s) begin
          state_d = DONE;
        end else begin
          if (sample_edge_s && (cnt_q < CW'(PACK_LENGTH))) begin
            rx_d  = shift_rx(rx_q, mosi_s);
            cnt_d = cnt_q + CW'(1'b1);
          end else if (shift_edge_s) begin
            // With CPHA=1 the first leading edge must not skip the pre-driven bit.
            if (first_q) begin
              first_d = 1'b0;
            end else if (idx_q < CW'(PACK_LENGTH - 1)) begin
              idx_d = idx_q + CW'(1'b1);
            end else begin
              idx_d = idx_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
          oe_d   = 1'b1;
          miso_d = tx_bit(tx_q, idx_d);
        end
      end
      DONE: begin
        if (commit_s) begin
          data_d   = rx_q;
          count_d  = count_q + 16'd1;
          done_d   = 1'b1;
          rd_ptr_d = rd_next_s;
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
          err_d = 1'b1;
        end
        if (!cs_level_s) begin
          state_d = ACTIVE;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d    = load_s ? load_word_s : tx_d;
    rx_d    = load_s ? '0 : rx_d;
    cnt_d   = load_s ? '0 : cnt_d;
    idx_d   = load_s ? '0 : idx_d;
    first_d = load_s ? (CPHA != 0) : first_d;
    oe_d    = load_s | oe_d;
    miso_d  = load_s ? tx_bit(load_word_s, CW'(0)) : miso_d;
  end

  // State, datapath and delay-line registers.
  always_ff @(posedge IN_CLK or negedge IN_RESET) begin
    if (!IN_RESET) begin
      state_q  <= IDLE;
      rx_q     <= '0;
      tx_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 16'd0;
      for (int i = 0; i < SLOTS; i++) delay_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (commit_s) delay_q[wr_ptr_q] <= rx_q;
    end
  end

  assign bus.MISO         = miso_q;
  assign bus.OUT_MISO_OE  = oe_q;
  assign OUT_RECEIVE_DATA = data_q;
  assign OUT_FRAME_DONE   = done_q;
  assign OUT_FRAME_ERROR  = err_q;
  assign OUT_FRAME_COUNT  = count_q;

endmodule

// File: tb/tb_spi_slave_delay_reflector.sv
// Bench: six reflector instances (all CPOL/CPHA modes, depths 4 and 1, reversed
// receive order) driven by an MSB-first master model and checked against a frame history.
module tb_spi_slave_delay_reflector;

  localparam int         NU     = 6;
  localparam logic [5:0] CPOL_V = 6'b011001;
  localparam logic [5:0] CPHA_V = 6'b010101;
  localparam logic [5:0] RXO_V  = 6'b011111;

  logic       clk = 1'b0;
  logic       rst_r  [NU];
  logic       sclk_r [NU];
  logic       cs_r   [NU];
  logic       mosi_r [NU];
  logic [1:0] mode_r [NU];
  logic       miso_w [NU];
  logic       oe_w   [NU];
  logic       done_w [NU];
  logic       err_w  [NU];
  logic [7:0] rdata_w [NU];
  logic [15:0] count_w [NU];

  logic [7:0] hist [NU][256];
  int         hist_n [NU];
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_u
    spi_slave_delay_reflector_if bus_i ();
    assign bus_i.SCLK = sclk_r[g];
    assign bus_i.CS   = cs_r[g];
    assign bus_i.MOSI = mosi_r[g];
    assign miso_w[g]  = bus_i.MISO;
    assign oe_w[g]    = bus_i.OUT_MISO_OE;

    spi_slave_delay_reflector #(
      .CPHA(CPHA_V[g] ? 1 : 0),
      .CPOL(CPOL_V[g] ? 1 : 0),
      .PACK_LENGTH(8),
      .PACK_BIT_SEQUENCE_TRANSMIT(1),
      .PACK_BIT_SEQUENCE_RECEIVE(RXO_V[g] ? 1 : 0),
      .DELAY_DEPTH((g == 0) ? 4 : 1),
      .FILL(8'h5A)
    ) dut (
      .IN_CLK(clk),
      .IN_RESET(rst_r[g]),
      .bus(bus_i),
      .IN_MODE(mode_r[g]),
      .OUT_RECEIVE_DATA(rdata_w[g]),
      .OUT_FRAME_DONE(done_w[g]),
      .OUT_FRAME_ERROR(err_w[g]),
      .OUT_FRAME_COUNT(count_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] xform(input logic [1:0] m, input logic [7:0] v);
    case (m)
      2'd0:    return v;
      2'd1:    return ~v;
      2'd2:    return v + 8'd1;
      default: return 8'h5A;
    endcase
  endfunction

  // Frame k answers with the word committed DELAY_DEPTH frames earlier, or zero.
  function automatic logic [7:0] expect_resp(input int u, input logic [1:0] m);
    int d;
    logic [7:0] src;
    d   = (u == 0) ? 4 : 1;
    src = (hist_n[u] >= d) ? hist[u][hist_n[u]-d] : 8'h00;
    return xform(m, src);
  endfunction

  task automatic check_zero(input int u);
    check("rst_miso",  {31'd0, miso_w[u]}, 32'd0);
    check("rst_oe",    {31'd0, oe_w[u]},   32'd0);
    check("rst_rdata", {24'd0, rdata_w[u]}, 32'd0);
    check("rst_count", {16'd0, count_w[u]}, 32'd0);
    check("rst_done",  {31'd0, done_w[u]}, 32'd0);
    check("rst_err",   {31'd0, err_w[u]},  32'd0);
  endtask

  task automatic do_frame(input int u, input logic [7:0] data, input int nbits, input int half,
                          input logic [1:0] m, input bit rst_mid, output logic [7:0] got);
    logic cpol, cpha;
    logic [7:0] exp_resp, rx_word, last;
    int cyc;
    bit seen;
    cpol     = CPOL_V[u];
    cpha     = CPHA_V[u];
    exp_resp = expect_resp(u, m);
    rx_word  = RXO_V[u] ? data : rev8(data);
    last     = (hist_n[u] > 0) ? hist[u][hist_n[u]-1] : 8'h00;
    got      = 8'h00;
    mode_r[u] = m;
    cs_r[u]   = 1'b0;
    mosi_r[u] = data[7];
    wclk(2);
    check("oe_early", {31'd0, oe_w[u]}, 32'd0);
    wclk(1);
    check("oe_on", {31'd0, oe_w[u]}, 32'd1);
    check("miso_first", {31'd0, miso_w[u]}, {31'd0, exp_resp[7]});
    wclk(half - 3);
    for (int i = 0; i < nbits; i++) begin
      if (cpha == 1'b0) begin
        sclk_r[u] = ~cpol;
        got[7-i]  = miso_w[u];
        wclk(half);
        sclk_r[u] = cpol;
        if (i < 7) mosi_r[u] = data[6-i];
        wclk(half);
      end else begin
        sclk_r[u] = ~cpol;
        mosi_r[u] = data[7-i];
        wclk(half);
        sclk_r[u] = cpol;
        got[7-i]  = miso_w[u];
        wclk(half);
      end
    end
    if (rst_mid) begin
      rst_r[u] = 1'b0;
      #2;
      check_zero(u);
      cs_r[u]   = 1'b1;
      sclk_r[u] = cpol;
      mosi_r[u] = 1'b0;
      wclk(2);
      rst_r[u]  = 1'b1;
      hist_n[u] = 0;
      wclk(4);
    end else begin
      cs_r[u] = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 12) begin
        wclk(1);
        cyc++;
        seen = done_w[u] | err_w[u];
      end
      check("pulse_latency", cyc, 32'd4);
      if (nbits == 8) begin
        check("frame_done", {31'd0, done_w[u]}, 32'd1);
        check("rx_data", {24'd0, rdata_w[u]}, {24'd0, rx_word});
        hist[u][hist_n[u]] = rx_word;
        hist_n[u]++;
        check("frame_count", {16'd0, count_w[u]}, hist_n[u]);
        check("response", {24'd0, got}, {24'd0, exp_resp});
      end else begin
        check("frame_error", {31'd0, err_w[u]}, 32'd1);
        check("count_hold", {16'd0, count_w[u]}, hist_n[u]);
        check("rx_hold", {24'd0, rdata_w[u]}, {24'd0, last});
      end
      wclk(1);
      check("pulse_width", {31'd0, done_w[u] | err_w[u]}, 32'd0);
      wclk(2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] resp [6];
    for (int u = 0; u < NU; u++) begin
      rst_r[u]  = 1'b0;
      sclk_r[u] = CPOL_V[u];
      cs_r[u]   = 1'b1;
      mosi_r[u] = 1'b0;
      mode_r[u] = 2'd0;
      hist_n[u] = 0;
    end
    wclk(3);
    for (int u = 0; u < NU; u++) check_zero(u);
    for (int u = 0; u < NU; u++) rst_r[u] = 1'b1;
    wclk(4);

    // Depth-4 latency: four zero answers, then the first two words.
    for (int k = 0; k < 6; k++) begin
      do_frame(0, 8'(8'h11 * (k + 1)), 8, 4, 2'd0, 1'b0, got);
      resp[k] = got;
    end
    check("d4_resp3", {24'd0, resp[3]}, 32'h00);
    check("d4_resp4", {24'd0, resp[4]}, 32'h11);
    check("d4_resp5", {24'd0, resp[5]}, 32'h22);
    check("d4_count", {16'd0, count_w[0]}, 32'd6);

    // All SPI modes at 8x and 16x oversampling.
    for (int u = 1; u <= 4; u++) begin
      for (int h = 4; h <= 8; h += 4) begin
        do_frame(u, 8'hA5, 8, h, 2'd0, 1'b0, got);
        do_frame(u, 8'h3C, 8, h, 2'd0, 1'b0, got);
        check("mode_pair", {24'd0, got}, 32'hA5);
      end
    end

    // Transform sweep.
    do_frame(1, 8'hF0, 8, 4, 2'd0, 1'b0, got);
    do_frame(1, 8'h00, 8, 4, 2'd1, 1'b0, got);
    check("xf_inv", {24'd0, got}, 32'h0F);
    do_frame(1, 8'hF0, 8, 4, 2'd0, 1'b0, got);
    do_frame(1, 8'h00, 8, 4, 2'd2, 1'b0, got);
    check("xf_inc", {24'd0, got}, 32'hF1);
    do_frame(1, 8'hFF, 8, 4, 2'd0, 1'b0, got);
    do_frame(1, 8'h00, 8, 4, 2'd2, 1'b0, got);
    check("xf_inc_wrap", {24'd0, got}, 32'h00);
    do_frame(1, 8'hF0, 8, 4, 2'd0, 1'b0, got);
    do_frame(1, 8'h00, 8, 4, 2'd3, 1'b0, got);
    check("xf_fill", {24'd0, got}, 32'h5A);

    // Aborted frame leaves the delay line untouched.
    do_frame(0, 8'h99, 5, 4, 2'd0, 1'b0, got);
    do_frame(0, 8'h77, 8, 4, 2'd0, 1'b0, got);
    check("abort_resp", {24'd0, got}, 32'h33);

    // LSB-first receive against an MSB-first master.
    do_frame(5, 8'h01, 8, 4, 2'd0, 1'b0, got);
    check("lsb_rx", {24'd0, rdata_w[5]}, 32'h80);
    do_frame(5, 8'h42, 8, 4, 2'd0, 1'b0, got);
    check("lsb_resp", {24'd0, got}, 32'h80);

    // Reset in the middle of frame 3 wipes the delay line.
    for (int k = 0; k < 3; k++) do_frame(0, 8'($urandom), 8, 4, 2'd0, 1'b0, got);
    do_frame(0, 8'hC3, 3, 4, 2'd0, 1'b1, got);
    for (int k = 0; k < 4; k++) begin
      do_frame(0, 8'($urandom), 8, 4, 2'd0, 1'b0, got);
      check("post_rst_zero", {24'd0, got}, 32'h00);
    end

    // Randomised traffic across all instances.
    for (int k = 0; k < 40; k++) begin
      do_frame(int'($urandom_range(0, NU - 1)), 8'($urandom), 8, int'($urandom_range(4, 8)),
               2'($urandom_range(0, 3)), 1'b0, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
